dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port A (CPU MEM stage) and port B (loader/debug).
//  Arbitrates per cycle: round-robin by default, with a lock so one side can hold the memory for atomic sequences.
//  Drives the memory's addr/WriteData/MemRead/MemWrite inputs.
//  Returns read data and a valid/error strobe to the winning port one cycle after its grant.
// PARAMETERS
//  DEPTH  32  memory words; legal addr_i range 0..DEPTH-1 (word index, no byte offset)
//  AW     32  address width of requester and memory ports
// PORTS
//  clk_i        in   1   clock; all state updates on posedge
//  rst_n_i      in   1   synchronous, active-low reset
//  a_req_i      in   1   port A request, held until a_gnt_o
//  a_we_i       in   1   1 = write, 0 = read
//  a_lock_i     in   1   keep grant after this access
//  a_addr_i     in   AW  word address
//  a_wdata_i    in   32  write data
//  a_gnt_o      out  1   access accepted this cycle (combinational)
//  a_rvalid_o   out  1   read data valid (registered, grant+1)
//  a_rdata_o    out  32  read data, meaningful only while a_rvalid_o
//  a_err_o      out  1   out-of-range access (registered, grant+1)
//  b_*          -    -   identical set for port B
//  mem_addr_o   out  AW  to memory addr_i
//  mem_wdata_o  out  32  to memory WriteData_i
//  mem_read_o   out  1   to memory MemRead_i
//  mem_write_o  out  1   to memory MemWrite_i
//  mem_rdata_i  in   32  from memory ReadData_o; valid the cycle after mem_read_o
// BEHAVIOUR
//  Reset (rst_n_i=0 at posedge): state=IDLE, prio=A. All *_rvalid_o, *_err_o and mem_* strobes are 0.
//    An access granted in the reset cycle is discarded: no rvalid/err follows.
//  FSM states: IDLE, LOCK_A, LOCK_B.
//  IDLE: one req -> grant it. Both -> grant side named by prio.
//  LOCK_X: only X may be granted; other side's gnt_o=0 even if X idle.
//  Lock transitions:
//    - Grant to X with X_lock_i=1 -> next state LOCK_X.
//    - In LOCK_X, grant with lock_i=0, or X_req_i=0 -> next state IDLE.
//  prio: after a grant to X in IDLE with lock_i=0, prio <= other side. Unchanged otherwise (incl. lock cycles).
//  At most one gnt_o per cycle. mem_* are a pure mux of the granted port.
//  mem_read_o / mem_write_o = gnt & ~we / gnt & we, gated by the range check.
//  Range check: addr >= DEPTH -> gnt still asserted, no mem strobe, X_err_o=1 next cycle, X_rvalid_o=0.
//  Read latency: exactly 1. X_rvalid_o=1 the cycle after an in-range read grant, X_rdata_o=mem_rdata_i.
//    Back-to-back reads give rvalid every cycle.
//  Writes: no rvalid. Memory updated at the grant edge. A read of the same addr granted next cycle returns new data.
//  No request ever waits more than one access in IDLE (round-robin); lock holder may starve the other side by design.
//  *_rdata_o = 0 when matching rvalid=0 (no stale data leakage).
// STRUCTURE
//  Shared package: FSM state encodings (IDLE/LOCK_A/LOCK_B), port id constants PORT_A/PORT_B, DEPTH default.
//  One natural sub-module: dmem_rr_pick (2-way round-robin picker: reqs, prio, lock state -> grant one-hot).
//  Rest (mux, range check, response regs) stays in this module.
// TESTING
//  A read addr 5 alone (mem[5]=0x1234) -> a_gnt_o same cycle, a_rvalid_o=1, a_rdata_o=0x1234 next cycle, b_* quiet.
//  A and B both read every cycle for 4 cycles from IDLE -> grants alternate A,B,A,B; each rvalid at grant+1.
//  A write+lock addr 3=0xAA, then A read addr 3 lock=0 while B requests throughout
//    -> B gnt=0 both cycles, a_rdata_o=0xAA, B granted cycle after.
//  B read addr 40 (DEPTH=32) -> b_gnt_o=1, mem_read_o=0, b_err_o=1 next cycle, b_rvalid_o=0.
//  A locked, then a_req_i drops with B pending -> state IDLE, B granted the following cycle.
//  rst_n_i low in cycle with A read granted -> next cycle all outputs 0, state IDLE, prio=A.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int DMEM_DEPTH = 32;
  localparam int DMEM_AW    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  function automatic port_id_e other_port(input port_id_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-way round-robin grant picker honouring the lock state
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
  input  port_id_e   prio,
  input  arb_state_e state,
  output logic       a_gnt,
  output logic       b_gnt
);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    case (state)
      // Lock holder owns the memory even while idle; the other side waits.
      LOCK_A: a_gnt = a_req;
      LOCK_B: b_gnt = b_req;
      default: begin
        if (a_req && (!b_req || prio == PORT_A)) begin
          a_gnt = 1'b1;
        end else if (b_req) begin
          b_gnt = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between CPU (A) and loader (B)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,

  input  logic          a_req_i,
  input  logic          a_we_i,
  input  logic          a_lock_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [31:0]   a_wdata_i,
  output logic          a_gnt_o,
  output logic          a_rvalid_o,
  output logic [31:0]   a_rdata_o,
  output logic          a_err_o,

  input  logic          b_req_i,
  input  logic          b_we_i,
  input  logic          b_lock_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [31:0]   b_wdata_i,
  output logic          b_gnt_o,
  output logic          b_rvalid_o,
  output logic [31:0]   b_rdata_o,
  output logic          b_err_o,

  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH);

  arb_state_e state_q;
  port_id_e   prio_q;
  logic       a_gnt;
  logic       b_gnt;
  logic       a_in_range;
  logic       b_in_range;
  logic       sel_we;
  logic       sel_in_range;
  logic       access_ok;
  logic       a_rvalid_q;
  logic       a_err_q;
  logic       b_rvalid_q;
  logic       b_err_q;

  dmem_rr_pick u_pick (
    .a_req (a_req_i),
    .b_req (b_req_i),
    .prio  (prio_q),
    .state (state_q),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign a_gnt_o = a_gnt;
  assign b_gnt_o = b_gnt;

  assign a_in_range = (a_addr_i < ADDR_LIMIT);
  assign b_in_range = (b_addr_i < ADDR_LIMIT);

  assign mem_addr_o   = b_gnt ? b_addr_i   : a_addr_i;
  assign mem_wdata_o  = b_gnt ? b_wdata_i  : a_wdata_i;
  assign sel_we       = b_gnt ? b_we_i     : a_we_i;
  assign sel_in_range = b_gnt ? b_in_range : a_in_range;

  // Strobes are suppressed during reset so a discarded access cannot touch memory.
  assign access_ok   = (a_gnt | b_gnt) & sel_in_range & rst_n_i;
  assign mem_read_o  = access_ok & ~sel_we;
  assign mem_write_o = access_ok & sel_we;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      prio_q     <= PORT_A;
      a_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_err_q    <= 1'b0;
    end else begin
      a_rvalid_q <= a_gnt & ~a_we_i & a_in_range;
      a_err_q    <= a_gnt & ~a_in_range;
      b_rvalid_q <= b_gnt & ~b_we_i & b_in_range;
      b_err_q    <= b_gnt & ~b_in_range;

      case (state_q)
        IDLE: begin
          // A locking grant keeps prio, so fairness resumes where it left off.
          if (a_gnt) begin
            if (a_lock_i) state_q <= LOCK_A;
            else          prio_q  <= other_port(PORT_A);
          end else if (b_gnt) begin
            if (b_lock_i) state_q <= LOCK_B;
            else          prio_q  <= other_port(PORT_B);
          end
        end
        LOCK_A: begin
          if (!a_req_i || !a_lock_i) state_q <= IDLE;
        end
        LOCK_B: begin
          if (!b_req_i || !b_lock_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_rvalid_o = a_rvalid_q;
  assign a_err_o    = a_err_q;
  assign b_rvalid_o = b_rvalid_q;
  assign b_err_o    = b_err_q;

  // Data bus is zeroed when not valid so stale reads never leak to the other port.
  assign a_rdata_o = a_rvalid_q ? mem_rdata_i : 32'h0;
  assign b_rdata_o = b_rvalid_q ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int          DEPTH   = 32;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam int          NROWS   = 18;

  logic        clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_n_i;
  logic        a_req_i, a_we_i, a_lock_i;
  logic [31:0] a_addr_i, a_wdata_i;
  logic        a_gnt_o, a_rvalid_o, a_err_o;
  logic [31:0] a_rdata_o;
  logic        b_req_i, b_we_i, b_lock_i;
  logic [31:0] b_addr_i, b_wdata_i;
  logic        b_gnt_o, b_rvalid_o, b_err_o;
  logic [31:0] b_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_read_o, mem_write_o;

  dmem_arbiter dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .a_req_i     (a_req_i),
    .a_we_i      (a_we_i),
    .a_lock_i    (a_lock_i),
    .a_addr_i    (a_addr_i),
    .a_wdata_i   (a_wdata_i),
    .a_gnt_o     (a_gnt_o),
    .a_rvalid_o  (a_rvalid_o),
    .a_rdata_o   (a_rdata_o),
    .a_err_o     (a_err_o),
    .b_req_i     (b_req_i),
    .b_we_i      (b_we_i),
    .b_lock_i    (b_lock_i),
    .b_addr_i    (b_addr_i),
    .b_wdata_i   (b_wdata_i),
    .b_gnt_o     (b_gnt_o),
    .b_rvalid_o  (b_rvalid_o),
    .b_rdata_o   (b_rdata_o),
    .b_err_o     (b_err_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_rdata_i (mem_rdata_i)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'h1234 : (32'h100 + 32'(i));
  endfunction

  // Physical single-port memory: write at the edge, registered read data.
  logic [31:0] phys_mem [DEPTH];
  logic        mem_init;
  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) phys_mem[i] <= init_word(i);
      mem_rdata_i <= 32'h0;
    end else begin
      if (mem_write_o) phys_mem[mem_addr_o[4:0]] <= mem_wdata_o;
      if (mem_read_o)  mem_rdata_i <= phys_mem[mem_addr_o[4:0]];
    end
  end

  // Directed vector: op 0 none, 1 read, 2 write, 3 read+lock, 4 write+lock.
  typedef struct {
    logic        rst_n;
    int          a_op;
    logic [31:0] a_addr, a_wdata;
    int          b_op;
    logic [31:0] b_addr;
    logic        e_agnt, e_bgnt, e_mrd, e_mwr;
    logic        e_arv, e_aerr;
    logic [31:0] e_ard;
    logic        e_brv, e_berr;
    logic [31:0] e_brd;
  } vec_t;

  vec_t tbl [NROWS];
  vec_t none_v;

  int tests, fails, cyc;

  // Reference model: lock owner (-1 none, 0 A, 1 B), priority side, word store.
  int          owner, prio;
  logic [31:0] ref_mem [DEPTH];
  logic        x_arv, x_aerr, x_brv, x_berr;
  logic [31:0] x_ard, x_brd;
  bit          m_ga, m_gb;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst_n, input int a_op, input int a_addr, input int a_wdata,
                              input int b_op, input int b_addr,
                              input logic e_agnt, input logic e_bgnt, input logic e_mrd, input logic e_mwr,
                              input logic e_arv, input logic e_aerr, input int e_ard,
                              input logic e_brv, input logic e_berr, input int e_brd);
    vec_t v;
    v.rst_n = rst_n; v.a_op = a_op; v.a_addr = 32'(a_addr); v.a_wdata = 32'(a_wdata);
    v.b_op = b_op; v.b_addr = 32'(b_addr);
    v.e_agnt = e_agnt; v.e_bgnt = e_bgnt; v.e_mrd = e_mrd; v.e_mwr = e_mwr;
    v.e_arv = e_arv; v.e_aerr = e_aerr; v.e_ard = 32'(e_ard);
    v.e_brv = e_brv; v.e_berr = e_berr; v.e_brd = 32'(e_brd);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n_i   = v.rst_n;
    a_req_i   = (v.a_op != 0);
    a_we_i    = (v.a_op == 2) || (v.a_op == 4);
    a_lock_i  = (v.a_op >= 3);
    a_addr_i  = v.a_addr;
    a_wdata_i = v.a_wdata;
    b_req_i   = (v.b_op != 0);
    b_we_i    = (v.b_op == 2) || (v.b_op == 4);
    b_lock_i  = (v.b_op >= 3);
    b_addr_i  = v.b_addr;
    b_wdata_i = 32'h5A5A_0000 | v.b_addr;
  endtask

  task automatic step(input bit use_row, input vec_t v);
    bit          ga, gb, a_in, b_in, e_mrd, e_mwr;
    logic [31:0] e_addr, e_wdata;
    ga = 0;
    gb = 0;
    if (owner == 0)      ga = a_req_i;
    else if (owner == 1) gb = b_req_i;
    else if (a_req_i && (!b_req_i || prio == 0)) ga = 1;
    else if (b_req_i)    gb = 1;
    a_in    = (a_addr_i < DEPTH_W);
    b_in    = (b_addr_i < DEPTH_W);
    e_mrd   = rst_n_i && ((ga && !a_we_i && a_in) || (gb && !b_we_i && b_in));
    e_mwr   = rst_n_i && ((ga && a_we_i && a_in) || (gb && b_we_i && b_in));
    e_addr  = gb ? b_addr_i : a_addr_i;
    e_wdata = gb ? b_wdata_i : a_wdata_i;

    @(negedge clk_i);
    chk1("a_gnt", a_gnt_o, ga);
    chk1("b_gnt", b_gnt_o, gb);
    chk1("mem_read", mem_read_o, e_mrd);
    chk1("mem_write", mem_write_o, e_mwr);
    if (e_mrd || e_mwr) chk32("mem_addr", mem_addr_o, e_addr);
    if (e_mwr)          chk32("mem_wdata", mem_wdata_o, e_wdata);
    chk1("a_rvalid", a_rvalid_o, x_arv);
    chk1("a_err", a_err_o, x_aerr);
    chk32("a_rdata", a_rdata_o, x_ard);
    chk1("b_rvalid", b_rvalid_o, x_brv);
    chk1("b_err", b_err_o, x_berr);
    chk32("b_rdata", b_rdata_o, x_brd);
    if (use_row) begin
      chk1("row_a_gnt", a_gnt_o, v.e_agnt);
      chk1("row_b_gnt", b_gnt_o, v.e_bgnt);
      chk1("row_mem_read", mem_read_o, v.e_mrd);
      chk1("row_mem_write", mem_write_o, v.e_mwr);
      chk1("row_a_rvalid", a_rvalid_o, v.e_arv);
      chk1("row_a_err", a_err_o, v.e_aerr);
      chk32("row_a_rdata", a_rdata_o, v.e_ard);
      chk1("row_b_rvalid", b_rvalid_o, v.e_brv);
      chk1("row_b_err", b_err_o, v.e_berr);
      chk32("row_b_rdata", b_rdata_o, v.e_brd);
    end

    @(posedge clk_i);
    m_ga = ga;
    m_gb = gb;
    if (!rst_n_i) begin
      owner = -1; prio = 0;
      x_arv = 0; x_aerr = 0; x_ard = 0;
      x_brv = 0; x_berr = 0; x_brd = 0;
    end else begin
      x_arv  = ga && !a_we_i && a_in;
      x_aerr = ga && !a_in;
      x_ard  = x_arv ? ref_mem[a_addr_i[4:0]] : 32'h0;
      x_brv  = gb && !b_we_i && b_in;
      x_berr = gb && !b_in;
      x_brd  = x_brv ? ref_mem[b_addr_i[4:0]] : 32'h0;
      if (ga && a_we_i && a_in) ref_mem[a_addr_i[4:0]] = a_wdata_i;
      if (gb && b_we_i && b_in) ref_mem[b_addr_i[4:0]] = b_wdata_i;
      if (owner < 0) begin
        if (ga && a_lock_i)      owner = 0;
        else if (gb && b_lock_i) owner = 1;
        else if (ga)             prio = 1;
        else if (gb)             prio = 0;
      end else if (owner == 0) begin
        if (!a_req_i || !a_lock_i) owner = -1;
      end else begin
        if (!b_req_i || !b_lock_i) owner = -1;
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(0, 9) == 0) ? 32'($urandom_range(32, 63)) : 32'($urandom_range(0, 31));
  endfunction

  initial begin
    tests = 0; fails = 0; cyc = 0;
    owner = -1; prio = 0;
    x_arv = 0; x_aerr = 0; x_ard = 0; x_brv = 0; x_berr = 0; x_brd = 0;
    m_ga = 0; m_gb = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    none_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1, 1, 5, 0,    0, 0, 1, 0, 1, 0, 0, 0, 0,      0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 'h1234, 0, 0, 0);
    tbl[2]  = mk(0, 1, 7, 0,    0, 0, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 0,    1, 2, 1, 0, 1, 0, 0, 0, 0,      0, 0, 0);
    tbl[4]  = mk(1, 1, 1, 0,    1, 2, 0, 1, 1, 0, 1, 0, 'h101,  0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 0,    1, 2, 1, 0, 1, 0, 0, 0, 0,      1, 0, 'h102);
    tbl[6]  = mk(1, 1, 1, 0,    1, 2, 0, 1, 1, 0, 1, 0, 'h101,  0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 'h102);
    tbl[8]  = mk(1, 4, 3, 'hAA, 1, 4, 1, 0, 0, 1, 0, 0, 0,      0, 0, 0);
    tbl[9]  = mk(1, 1, 3, 0,    1, 4, 1, 0, 1, 0, 0, 0, 0,      0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0,    1, 4, 0, 1, 1, 0, 1, 0, 'hAA,   0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 'h104);
    tbl[12] = mk(1, 0, 0, 0,    1, 40, 0, 1, 0, 0, 0, 0, 0,     0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 0);
    tbl[14] = mk(1, 3, 6, 0,    1, 8, 1, 0, 1, 0, 0, 0, 0,      0, 0, 0);
    tbl[15] = mk(1, 0, 0, 0,    1, 8, 0, 0, 0, 0, 1, 0, 'h106,  0, 0, 0);
    tbl[16] = mk(1, 0, 0, 0,    1, 8, 0, 1, 1, 0, 0, 0, 0,      0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 'h108);

    apply(none_v);
    rst_n_i  = 1'b0;
    mem_init = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    mem_init = 1'b0;

    for (int r = 0; r < NROWS; r++) begin
      apply(tbl[r]);
      step(1, tbl[r]);
    end

    // Randomized traffic; a pending request is held until granted.
    apply(none_v);
    m_ga = 0; m_gb = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!a_req_i || m_ga) begin
        a_req_i   = ($urandom_range(0, 3) != 0);
        a_we_i    = ($urandom_range(0, 1) == 1);
        a_lock_i  = ($urandom_range(0, 4) == 0);
        a_addr_i  = rand_addr();
        a_wdata_i = $urandom();
      end
      if (!b_req_i || m_gb) begin
        b_req_i   = ($urandom_range(0, 3) != 0);
        b_we_i    = ($urandom_range(0, 1) == 1);
        b_lock_i  = ($urandom_range(0, 4) == 0);
        b_addr_i  = rand_addr();
        b_wdata_i = $urandom();
      end
      rst_n_i = ($urandom_range(0, 199) != 0);
      step(0, none_v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
